// File: rtl/regfile_ctx_mover.sv
// Bulk save/restore mover for the 2R1W register file (context switch / debug dump).
// Define REGMOVE_R0_PROTECT_EN to suppress RESTORE writes that target index 0.
module regfile_ctx_mover #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [AW-1:0]      cmd_base,
  input  logic [AW:0]        cmd_count,
  output logic [AW-1:0]      rf_rd_addr1,
  input  logic [WIDTH-1:0]   rf_rd_data1,
  output logic [AW-1:0]      rf_rd_addr2,
  input  logic [WIDTH-1:0]   rf_rd_data2,
  output logic               rf_wr_en,
  output logic [AW-1:0]      rf_wr_addr,
  output logic [WIDTH-1:0]   rf_wr_data,
  output logic               so_valid,
  input  logic               so_ready,
  output logic [2*WIDTH-1:0] so_data,
  output logic [1:0]         so_keep,
  output logic               so_last,
  input  logic               si_valid,
  output logic               si_ready,
  input  logic [WIDTH-1:0]   si_data,
  input  logic               si_last,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {S_IDLE, S_SAVE, S_RESTORE, S_FAIL, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t        r_state, w_nstate;
  logic [AW-1:0] r_base;
  logic [AW:0]   r_cnt, r_i;
  logic          r_err;

  logic          w_accept, w_legal, w_save_go, w_in_save, w_load;
  logic          w_so_fire, w_si_fire, w_final, w_wr_ok;
  logic [AW-1:0] w_base, w_addr1, w_wr_addr;
  logic [AW:0]   w_cnt, w_i, w_rem;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_legal   = (cmd_count != '0) && (cmd_count <= DEPTH_C);
  assign w_save_go = w_accept && w_legal && !cmd_op;
  assign w_in_save = (r_state == S_SAVE);

  // The first beat is read straight from the command so it is valid the cycle after accept.
  assign w_base  = w_in_save ? r_base : cmd_base;
  assign w_cnt   = w_in_save ? r_cnt  : cmd_count;
  assign w_i     = w_in_save ? r_i    : '0;
  assign w_rem   = w_cnt - w_i;
  assign w_addr1 = w_base + w_i[AW-1:0];

  assign rf_rd_addr1 = (w_save_go || w_in_save) ? w_addr1 : '0;
  assign rf_rd_addr2 = (w_save_go || w_in_save) ? w_addr1 + AW'(1) : '0;

  assign w_so_fire = so_valid && so_ready;
  assign w_load    = w_save_go || (w_in_save && (!so_valid || so_ready) && (r_i < r_cnt));
  assign w_si_fire = si_valid && si_ready;
  assign w_final   = (r_i == r_cnt - (AW+1)'(1));
  assign w_wr_addr = r_base + r_i[AW-1:0];

`ifdef REGMOVE_R0_PROTECT_EN
  assign w_wr_ok = (w_wr_addr != '0);
`else
  assign w_wr_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nstate;
  end

  always_comb begin
    w_nstate  = r_state;
    cmd_ready = 1'b0;
    si_ready  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_nstate = !w_legal ? S_FAIL : (cmd_op ? S_RESTORE : S_SAVE);
      end
      S_SAVE:    if (w_so_fire && so_last) w_nstate = S_DONE;
      S_RESTORE: begin
        si_ready = 1'b1;
        if (si_valid && (w_final || si_last)) w_nstate = S_DONE;
      end
      S_FAIL:    w_nstate = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        err      = r_err;
        w_nstate = S_IDLE;
      end
      default:   w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base     <= '0;
      r_cnt      <= '0;
      r_i        <= '0;
      r_err      <= 1'b0;
      so_valid   <= 1'b0;
      so_data    <= '0;
      so_keep    <= '0;
      so_last    <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      if (w_accept) begin
        r_base <= cmd_base;
        r_cnt  <= cmd_count;
        r_i    <= '0;
        r_err  <= !w_legal;
      end
      // An odd tail leaves the upper lane empty and zeroed.
      if (w_load) begin
        so_valid <= 1'b1;
        so_data  <= {(w_rem == (AW+1)'(1)) ? {WIDTH{1'b0}} : rf_rd_data2, rf_rd_data1};
        so_keep  <= (w_rem == (AW+1)'(1)) ? 2'b01 : 2'b11;
        so_last  <= (w_rem <= (AW+1)'(2));
        r_i      <= w_i + (AW+1)'(2);
      end else if (w_so_fire) begin
        so_valid <= 1'b0;
        so_data  <= '0;
        so_keep  <= '0;
        so_last  <= 1'b0;
      end
      rf_wr_en <= w_si_fire && w_wr_ok;
      if (w_si_fire) begin
        rf_wr_addr <= w_wr_addr;
        rf_wr_data <= si_data;
        r_i        <= r_i + (AW+1)'(1);
        if (w_final)      r_err <= !si_last;
        else if (si_last) r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_ctx_mover.sv
// Directed bench for regfile_ctx_mover: command vector table plus reset-abort sequences.
module tb_regfile_ctx_mover;
  localparam int WIDTH = 32;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
`ifdef REGMOVE_R0_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [AW-1:0]      cmd_base = '0;
  logic [AW:0]        cmd_count = '0;
  logic [AW-1:0]      rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic [WIDTH-1:0]   rf_rd_data1, rf_rd_data2, rf_wr_data;
  logic               rf_wr_en;
  logic               so_valid, so_ready = 1'b0, so_last;
  logic [2*WIDTH-1:0] so_data;
  logic [1:0]         so_keep;
  logic               si_valid = 1'b0, si_ready, si_last = 1'b0;
  logic [WIDTH-1:0]   si_data = '0;
  logic               done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register file model: combinational reads, write at the clock edge.
  logic [WIDTH-1:0] rf [DEPTH];
  logic             preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++)
        rf[i] <= (i >= 4 && i <= 8) ? 32'(i + 12) : (32'hC000_0000 | 32'(i));
    end else if (rf_wr_en) begin
      rf[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_rd_data1 = rf[rf_rd_addr1];
  assign rf_rd_data2 = rf[rf_rd_addr2];

  regfile_ctx_mover #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_data1(rf_rd_data1),
    .rf_rd_addr2(rf_rd_addr2), .rf_rd_data2(rf_rd_data2),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .so_valid(so_valid), .so_ready(so_ready), .so_data(so_data),
    .so_keep(so_keep), .so_last(so_last),
    .si_valid(si_valid), .si_ready(si_ready), .si_data(si_data), .si_last(si_last),
    .done(done), .err(err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [1:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    string name;
    logic  op;
    int    base;
    int    count;
    int    nsend;
    int    last_at;
    bit    gaps;
    bit    stall;
    logic  exp_err;
    int    exp_lat;
    int    b_lo;
    int    b_n;
  } vec_t;

  beat_t beats[7];
  vec_t  vecs[9];

  initial begin
    int k, bi, t;
    bit gap, wpend, wexp, saw_wr, saw_sov, got, fail;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    beats[0] = '{64'h00000011_00000010, 2'b11, 1'b0};
    beats[1] = '{64'h00000013_00000012, 2'b11, 1'b0};
    beats[2] = '{64'h00000000_00000014, 2'b01, 1'b1};
    beats[3] = '{64'hC000007F_C000007E, 2'b11, 1'b0};
    beats[4] = '{64'hC0000001_C0000000, 2'b11, 1'b1};
    beats[5] = '{64'hA0000201_A0000200, 2'b11, 1'b0};
    beats[6] = '{64'h00000000_A0000202, 2'b01, 1'b1};

    //          name         op    base cnt  ns last gap stl err   lat lo n
    vecs[0] = '{"save5",     1'b0, 4,   5,   0, -1, 0,  0,  1'b0, 4,  0, 3};
    vecs[1] = '{"savewrap",  1'b0, 126, 4,   0, -1, 0,  1,  1'b0, 5,  3, 2};
    vecs[2] = '{"rest3gap",  1'b1, 10,  3,   3, 2,  1,  0,  1'b0, 6,  0, 0};
    vecs[3] = '{"restearly", 1'b1, 20,  4,   2, 1,  0,  0,  1'b1, 3,  0, 0};
    vecs[4] = '{"restnolast",1'b1, 30,  2,   3, -1, 0,  0,  1'b1, 3,  0, 0};
    vecs[5] = '{"cnt0",      1'b0, 50,  0,   0, -1, 0,  0,  1'b1, 2,  0, 0};
    vecs[6] = '{"cnt129",    1'b1, 50,  129, 2, 1,  0,  0,  1'b1, 2,  0, 0};
    vecs[7] = '{"restwrap",  1'b1, 127, 2,   2, 1,  0,  0,  1'b0, 3,  0, 0};
    vecs[8] = '{"saveback",  1'b0, 10,  3,   0, -1, 0,  0,  1'b0, 3,  5, 2};

    repeat (3) @(negedge clk);
    chk("rst.cmd_ready", cmd_ready, 1);
    chk("rst.so_valid", so_valid, 0);
    chk("rst.si_ready", si_ready, 0);
    chk("rst.rf_wr_en", rf_wr_en, 0);
    chk("rst.done_err", {done, err}, 0);
    chk("rst.rd_addr", {rf_rd_addr1, rf_rd_addr2}, 0);
    preload = 1'b0;
    rst = 1'b1;

    for (int v = 0; v < 9; v++) begin
      fail = (vecs[v].count == 0) || (vecs[v].count > DEPTH);
      @(negedge clk);
      chk({vecs[v].name, ".cmd_ready"}, cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = vecs[v].op;
      cmd_base  = AW'(vecs[v].base);
      cmd_count = 8'(vecs[v].count);
      k = 0; bi = vecs[v].b_lo; gap = 0; wpend = 0; wexp = 0;
      saw_wr = 0; saw_sov = 0; got = 0;
      waddr = '0; wdata = '0;
      for (t = 1; t <= 40 && !got; t++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        if (wpend) begin
          chk({vecs[v].name, ".wr_en"}, rf_wr_en, wexp);
          if (wexp) chk({vecs[v].name, ".wr_addr_data"}, {rf_wr_addr, rf_wr_data}, {waddr, wdata});
          wpend = 0;
        end else if (rf_wr_en) begin
          saw_wr = 1;
        end
        if (so_valid && (vecs[v].op || fail)) saw_sov = 1;
        if (!vecs[v].op && !fail) begin
          so_ready = vecs[v].stall ? (t % 2 == 0) : 1'b1;
          if (so_valid) begin
            if (bi < vecs[v].b_lo + vecs[v].b_n)
              chk({vecs[v].name, ".beat"}, {so_data[63:0], so_keep, so_last},
                  {beats[bi].data, beats[bi].keep, beats[bi].last});
            else
              chk({vecs[v].name, ".extra_beat"}, so_valid, 0);
            if (so_ready) bi++;
          end
        end else if (vecs[v].op && !fail) begin
          if (gap) begin
            si_valid = 1'b0;
            gap = 0;
          end else if (k < vecs[v].nsend) begin
            si_valid = 1'b1;
            si_data  = 32'hA000_0000 | 32'(v << 8) | 32'(k);
            si_last  = (k == vecs[v].last_at);
            if (si_ready) begin
              wpend = 1;
              waddr = AW'(vecs[v].base + k);
              wdata = si_data;
              wexp  = !(PROT && waddr == '0);
              k++;
              gap = vecs[v].gaps;
            end
          end else begin
            si_valid = 1'b0;
          end
        end
        if (done) begin
          got = 1;
          chk({vecs[v].name, ".latency"}, 64'(t), 64'(vecs[v].exp_lat));
          chk({vecs[v].name, ".err"}, err, vecs[v].exp_err);
        end
      end
      if (!got) chk({vecs[v].name, ".timeout"}, 0, 1);
      @(negedge clk);
      si_valid = 1'b0; si_last = 1'b0; so_ready = 1'b0;
      chk({vecs[v].name, ".idle"}, {cmd_ready, rf_wr_en, done}, 3'b100);
      chk({vecs[v].name, ".no_stray_wr"}, saw_wr, 0);
      chk({vecs[v].name, ".no_stray_so"}, saw_sov, 0);
      if (!vecs[v].op && !fail) chk({vecs[v].name, ".nbeats"}, 64'(bi), 64'(vecs[v].b_lo + vecs[v].b_n));
    end

    chk("rf.R10", rf[10], 32'hA0000200);
    chk("rf.R12", rf[12], 32'hA0000202);
    chk("rf.R20", rf[20], 32'hA0000300);
    chk("rf.R21", rf[21], 32'hA0000301);
    chk("rf.R22_untouched", rf[22], 32'hC0000016);
    chk("rf.R31", rf[31], 32'hA0000401);
    chk("rf.R32_untouched", rf[32], 32'hC0000020);
    chk("rf.R50_untouched", rf[50], 32'hC0000032);
    chk("rf.R127", rf[127], 32'hA0000700);
    chk("rf.R0", rf[0], PROT ? 32'hC0000000 : 32'hA0000701);

    // Reset in the middle of a stalled SAVE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 7'd4; cmd_count = 8'd5; so_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rsave.pre_valid", so_valid, 1);
    rst = 1'b0;
    #1;
    chk("rsave.outs", {so_valid, so_keep, so_last, done, err}, 0);
    chk("rsave.data", so_data, 0);
    chk("rsave.cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rsave.after", {cmd_ready, so_valid, done}, 3'b100);

    // Reset in the middle of a RESTORE with a write in flight.
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 7'd40; cmd_count = 8'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    si_valid = 1'b1; si_data = 32'h5555_0000; si_last = 1'b0;
    chk("rrest.si_ready", si_ready, 1);
    @(negedge clk);
    si_valid = 1'b0;
    chk("rrest.wr_en", rf_wr_en, 1);
    rst = 1'b0;
    #1;
    chk("rrest.outs", {rf_wr_en, si_ready, done, cmd_ready}, 4'b0001);
    chk("rrest.wr_addr_data", {rf_wr_addr, rf_wr_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rrest.after", {cmd_ready, si_ready, rf_wr_en}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
